// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: request/grant + response-valid instruction memory bus. Rev 1.0
`default_nettype none

interface if_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing one-outstanding imem fetches, with branch redirect/flush. Rev 1.0
// Build option FETCH_PERF_EN enables fetch/redirect counters; otherwise those ports read 0.
`default_nettype none

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  wire                 clk_i,
   input  wire                 rst_i,
   input  wire                 start_i,
   input  wire                 Stall_i,
   input  wire                 Branch_i,
   input  wire  [31:0]         branch_pc_i,
   if_fetch_unit_if.master     imem,
   output logic [31:0]         pc_o,
   output logic [31:0]         instr_o,
   output logic                valid_o,
   output logic                Flush_o,
   output logic [31:0]         fetch_cnt_o,
   output logic [31:0]         redirect_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_drop;
   logic [31:0] r_buf;
   logic        r_req;
   logic        r_valid;

   wire  [31:0] w_pc_inc     = r_pc + 32'd4;
   wire  [31:0] w_branch_tgt = {branch_pc_i[31:2], 2'b00};

   // r_buf is only non-zero while in HOLD, so it drives instr_o directly.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_drop  <= 1'b0;
         r_buf   <= 32'd0;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
      end else if (Branch_i) begin
         r_pc <= w_branch_tgt;
         case (r_state)
            S_REQ: begin
               if (imem.gnt) begin
                  r_state <= S_WAIT;
                  r_drop  <= 1'b1;
                  r_req   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem.rvalid) begin
                  r_state <= S_REQ;
                  r_drop  <= 1'b0;
                  r_req   <= 1'b1;
               end else begin
                  r_drop  <= 1'b1;
               end
            end
            S_HOLD: begin
               r_state <= S_REQ;
               r_buf   <= 32'd0;
               r_valid <= 1'b0;
               r_req   <= 1'b1;
            end
            default: ;
         endcase
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
               end
            end
            S_REQ: begin
               if (imem.gnt) begin
                  r_state <= S_WAIT;
                  r_req   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem.rvalid) begin
                  if (r_drop) begin
                     r_drop  <= 1'b0;
                     r_state <= S_REQ;
                     r_req   <= 1'b1;
                  end else begin
                     r_buf   <= imem.rdata;
                     r_state <= S_HOLD;
                     r_valid <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (!Stall_i) begin
                  r_pc    <= w_pc_inc;
                  r_buf   <= 32'd0;
                  r_state <= S_REQ;
                  r_valid <= 1'b0;
                  r_req   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign imem.req  = r_req;
   assign imem.addr = r_pc;
   assign pc_o      = r_pc;
   assign instr_o   = r_buf;
   assign valid_o   = r_valid;
   assign Flush_o   = Branch_i;

`ifdef FETCH_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_redirect_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_fetch_cnt    <= 32'd0;
         r_redirect_cnt <= 32'd0;
      end else begin
         if (r_state == S_HOLD && !Stall_i && !Branch_i)
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (Branch_i)
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
   end

   assign fetch_cnt_o    = r_fetch_cnt;
   assign redirect_cnt_o = r_redirect_cnt;
`else
   assign fetch_cnt_o    = 32'd0;
   assign redirect_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for if_fetch_unit. Rev 1.0
`default_nettype none

module tb_if_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        Stall_i;
   logic        Branch_i;
   logic [31:0] branch_pc_i;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        valid_o;
   logic        Flush_o;
   logic [31:0] fetch_cnt_o;
   logic [31:0] redirect_cnt_o;

   int n_total = 0;
   int n_bad   = 0;

   if_fetch_unit_if imem_bus ();

   if_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .Stall_i        (Stall_i),
      .Branch_i       (Branch_i),
      .branch_pc_i    (branch_pc_i),
      .imem           (imem_bus),
      .pc_o           (pc_o),
      .instr_o        (instr_o),
      .valid_o        (valid_o),
      .Flush_o        (Flush_o),
      .fetch_cnt_o    (fetch_cnt_o),
      .redirect_cnt_o (redirect_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Entered in REQ; leaves the DUT back in REQ for the next address.
   task automatic fetch_one(input logic [31:0] a, input logic [31:0] d, input int stalls);
      check_val("req_hi",   {31'd0, imem_bus.req}, 32'd1);
      check_val("req_addr", imem_bus.addr, a);
      imem_bus.gnt = 1'b1;
      tick();
      imem_bus.gnt = 1'b0;
      check_val("wait_req", {31'd0, imem_bus.req}, 32'd0);
      check_val("wait_vld", {31'd0, valid_o}, 32'd0);
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = d;
      tick();
      imem_bus.rvalid = 1'b0;
      check_val("hold_vld",   {31'd0, valid_o}, 32'd1);
      check_val("hold_instr", instr_o, d);
      check_val("hold_pc",    pc_o, a);
      for (int i = 0; i < stalls; i++) begin
         Stall_i = 1'b1;
         tick();
         check_val("stall_vld",   {31'd0, valid_o}, 32'd1);
         check_val("stall_instr", instr_o, d);
         check_val("stall_pc",    pc_o, a);
         check_val("stall_req",   {31'd0, imem_bus.req}, 32'd0);
      end
      Stall_i = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] exp_fetch;
      logic [31:0] exp_redir;
      rst_i           = 1'b0;
      start_i         = 1'b0;
      Stall_i         = 1'b0;
      Branch_i        = 1'b0;
      branch_pc_i     = 32'd0;
      imem_bus.gnt    = 1'b0;
      imem_bus.rvalid = 1'b0;
      imem_bus.rdata  = 32'd0;
      tick();
      tick();
      check_val("rst_req",   {31'd0, imem_bus.req}, 32'd0);
      check_val("rst_addr",  imem_bus.addr, 32'h100);
      check_val("rst_pc",    pc_o, 32'h100);
      check_val("rst_instr", instr_o, 32'd0);
      check_val("rst_vld",   {31'd0, valid_o}, 32'd0);
      check_val("rst_flush", {31'd0, Flush_o}, 32'd0);

      // Sequential fetches, last one stalled for three cycles
      rst_i   = 1'b1;
      start_i = 1'b1;
      tick();
      fetch_one(32'h100, 32'h1111_1111, 0);
      fetch_one(32'h104, 32'h2222_2222, 0);
      fetch_one(32'h108, 32'h3333_3333, 3);
      check_val("after_stall_addr", imem_bus.addr, 32'h10C);

      // Redirect while WAIT; late stale response must be dropped
      imem_bus.gnt = 1'b1;
      tick();
      imem_bus.gnt = 1'b0;
      Branch_i     = 1'b1;
      branch_pc_i  = 32'h203;
      #1;
      check_val("br_flush", {31'd0, Flush_o}, 32'd1);
      tick();
      Branch_i = 1'b0;
      check_val("br_flush_off", {31'd0, Flush_o}, 32'd0);
      check_val("br_w1_instr",  instr_o, 32'd0);
      tick();
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = 32'h0000_DEAD;
      check_val("br_w2_vld", {31'd0, valid_o}, 32'd0);
      tick();
      imem_bus.rvalid = 1'b0;
      check_val("br_drop_instr", instr_o, 32'd0);
      check_val("br_drop_vld",   {31'd0, valid_o}, 32'd0);
      check_val("br_req",        {31'd0, imem_bus.req}, 32'd1);
      check_val("br_addr",       imem_bus.addr, 32'h200);

      // Redirect in the same cycle as rvalid
      imem_bus.gnt = 1'b1;
      tick();
      imem_bus.gnt    = 1'b0;
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = 32'h0000_BEEF;
      Branch_i        = 1'b1;
      branch_pc_i     = 32'h300;
      tick();
      imem_bus.rvalid = 1'b0;
      Branch_i        = 1'b0;
      check_val("brrv_vld",   {31'd0, valid_o}, 32'd0);
      check_val("brrv_instr", instr_o, 32'd0);
      check_val("brrv_addr",  imem_bus.addr, 32'h300);

      // Redirect during a stalled HOLD
      imem_bus.gnt = 1'b1;
      tick();
      imem_bus.gnt    = 1'b0;
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = 32'h0000_0044;
      tick();
      imem_bus.rvalid = 1'b0;
      check_val("brh_vld_pre", {31'd0, valid_o}, 32'd1);
      Stall_i     = 1'b1;
      Branch_i    = 1'b1;
      branch_pc_i = 32'h400;
      tick();
      Stall_i  = 1'b0;
      Branch_i = 1'b0;
      check_val("brh_vld",   {31'd0, valid_o}, 32'd0);
      check_val("brh_instr", instr_o, 32'd0);
      check_val("brh_req",   {31'd0, imem_bus.req}, 32'd1);
      check_val("brh_addr",  imem_bus.addr, 32'h400);

      // Reset mid-WAIT, stale response arrives in IDLE
      imem_bus.gnt = 1'b1;
      tick();
      imem_bus.gnt = 1'b0;
      rst_i        = 1'b0;
      start_i      = 1'b0;
      tick();
      rst_i           = 1'b1;
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = 32'h0000_0BAD;
      check_val("rst2_req",  {31'd0, imem_bus.req}, 32'd0);
      check_val("rst2_addr", imem_bus.addr, 32'h100);
      check_val("rst2_pc",   pc_o, 32'h100);
      tick();
      imem_bus.rvalid = 1'b0;
      check_val("rst2_vld",   {31'd0, valid_o}, 32'd0);
      check_val("rst2_instr", instr_o, 32'd0);
      check_val("rst2_idle",  {31'd0, imem_bus.req}, 32'd0);
      check_val("rst2_fcnt",  fetch_cnt_o, 32'd0);
      check_val("rst2_rcnt",  redirect_cnt_o, 32'd0);
      start_i = 1'b1;
      tick();
      check_val("restart_req",  {31'd0, imem_bus.req}, 32'd1);
      check_val("restart_addr", imem_bus.addr, 32'h100);

      // PC wrap plus counters: one redirect then three fetches
      Branch_i    = 1'b1;
      branch_pc_i = 32'hFFFF_FFFC;
      tick();
      Branch_i = 1'b0;
      fetch_one(32'hFFFF_FFFC, 32'hAAAA_0001, 0);
      fetch_one(32'h0000_0000, 32'hAAAA_0002, 0);
      fetch_one(32'h0000_0004, 32'hAAAA_0003, 0);
      check_val("wrap_addr", imem_bus.addr, 32'h8);
`ifdef FETCH_PERF_EN
      exp_fetch = 32'd3;
      exp_redir = 32'd1;
`else
      exp_fetch = 32'd0;
      exp_redir = 32'd0;
`endif
      check_val("fetch_cnt",    fetch_cnt_o, exp_fetch);
      check_val("redirect_cnt", redirect_cnt_o, exp_redir);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
